cnn_layer_accel_weight_sequencer: RTL and testbench

//  Upstream driver of the weight sequence table. Generates gray_code, sequence_selector and
//  seq_data_addr so the table walks its kernel-tap sequences in a fixed order.
//  Run on a start/done handshake; length set per job; stall freezes the walk.

---
 rtl/cnn_layer_accel_weight_sequencer.sv | 128 ++++++++++++
 tb/tb_cnn_layer_accel_weight_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// Weight sequence table driver: walks gray/selector/address beats for a job of
// cfg_num_iter iterations under a start/done handshake, with stall support.
module cnn_layer_accel_weight_sequencer #(
    parameter int unsigned SEQ_LEN = 5,
    parameter int unsigned ITER_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] cfg_num_iter,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [1:0]        gray_code,
    output logic              sequence_selector,
    output logic [2:0]        seq_data_addr,
    output logic              seq_valid,
    output logic              wht_addr_valid
);

    localparam logic [2:0] LAST_ADDR = 3'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state, state_d;
    logic [ITER_W-1:0]   num_iter, num_iter_d;
    logic [ITER_W-1:0]   iter_cnt, iter_cnt_d;
    logic [1:0]          gray_d;
    logic                sel_d;
    logic [2:0]          addr_d;
    logic                busy_d, done_d, seq_valid_d;
    logic                last_beat_c;

    assign last_beat_c = !sequence_selector && (seq_data_addr == LAST_ADDR)
                         && (iter_cnt == num_iter - ITER_W'(1));

    // Next-state and next-output logic; a stalled cycle holds the pending triple.
    always_comb begin
        state_d     = state;
        num_iter_d  = num_iter;
        iter_cnt_d  = iter_cnt;
        gray_d      = gray_code;
        sel_d       = sequence_selector;
        addr_d      = seq_data_addr;
        busy_d      = busy;
        done_d      = 1'b0;
        seq_valid_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    num_iter_d = cfg_num_iter;
                    iter_cnt_d = '0;
                    gray_d     = 2'b00;
                    sel_d      = 1'b1;
                    addr_d     = 3'd0;
                    busy_d     = 1'b1;
                    if (cfg_num_iter != '0) begin
                        state_d     = S_RUN;
                        seq_valid_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_RUN: begin
                if (seq_valid && last_beat_c) begin
                    state_d = S_DRAIN;
                end else begin
                    if (seq_valid) begin
                        if (seq_data_addr != LAST_ADDR) begin
                            addr_d = seq_data_addr + 3'd1;
                        end else if (sequence_selector) begin
                            sel_d  = 1'b0;
                            addr_d = 3'd0;
                        end else begin
                            sel_d      = 1'b1;
                            addr_d     = 3'd0;
                            gray_d     = {gray_code[0], ~gray_code[1]};
                            iter_cnt_d = iter_cnt + ITER_W'(1);
                        end
                    end
                    seq_valid_d = !stall;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            num_iter          <= '0;
            iter_cnt          <= '0;
            gray_code         <= 2'b00;
            sequence_selector <= 1'b1;
            seq_data_addr     <= 3'd0;
            busy              <= 1'b0;
            done              <= 1'b0;
            seq_valid         <= 1'b0;
            wht_addr_valid    <= 1'b0;
        end else begin
            state             <= state_d;
            num_iter          <= num_iter_d;
            iter_cnt          <= iter_cnt_d;
            gray_code         <= gray_d;
            sequence_selector <= sel_d;
            seq_data_addr     <= addr_d;
            busy              <= busy_d;
            done              <= done_d;
            seq_valid         <= seq_valid_d;
            wht_addr_valid    <= seq_valid;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// Bench for cnn_layer_accel_weight_sequencer: expected beat lists are built from
// nested iteration/selector/address loops and compared cycle by cycle.
module tb_cnn_layer_accel_weight_sequencer;

    localparam int unsigned SEQ_LEN = 5;
    localparam int unsigned ITER_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ITER_W-1:0] cfg_num_iter;
    logic              stall;
    logic              busy, done, sequence_selector, seq_valid, wht_addr_valid;
    logic [1:0]        gray_code;
    logic [2:0]        seq_data_addr;

    int checks = 0;
    int passes = 0;

    cnn_layer_accel_weight_sequencer #(.SEQ_LEN(SEQ_LEN), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_iter(cfg_num_iter), .stall(stall),
        .busy(busy), .done(done), .gray_code(gray_code), .sequence_selector(sequence_selector),
        .seq_data_addr(seq_data_addr), .seq_valid(seq_valid), .wht_addr_valid(wht_addr_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job; t counts cycles after the start cycle (t0). Returns cycle of done.
    task automatic run_job(input int cfg, input int stall_pct, input logic [63:0] stall_mask,
                           input bit noisy_start, output int done_t);
        logic [5:0] exp_q[$];
        logic [5:0] obs;
        int bi, last_t, t;
        bit prev_stall, prev_valid, finished, exp_valid, exp_done;
        exp_q = {};
        for (int it = 0; it < cfg; it++)
            for (int s = 1; s >= 0; s--)
                for (int a = 0; a < int'(SEQ_LEN); a++)
                    exp_q.push_back({2'((it % 4) ^ ((it % 4) >> 1)), 1'(s), 3'(a)});
        bi = 0; last_t = -1; prev_stall = 0; prev_valid = 0; finished = 0; done_t = -1;
        cfg_num_iter = ITER_W'(cfg); start = 1'b1; stall = 1'b0;
        step();
        start = 1'b0;
        t = 1;
        while (!finished && t < 5000) begin
            obs = {gray_code, sequence_selector, seq_data_addr};
            exp_valid = (bi < exp_q.size()) && (t == 1 || !prev_stall);
            checks++;
            if (seq_valid !== exp_valid)
                $display("FAIL seq_valid cfg=%0d t=%0d: got %b expected %b", cfg, t, seq_valid, exp_valid);
            else passes++;
            if (bi < exp_q.size()) begin
                checks++;
                if (obs !== exp_q[bi])
                    $display("FAIL triple cfg=%0d t=%0d beat=%0d: got %h expected %h", cfg, t, bi, obs, exp_q[bi]);
                else passes++;
                if (seq_valid) begin
                    bi++;
                    if (bi == exp_q.size()) last_t = t;
                end
            end
            checks++;
            if (wht_addr_valid !== prev_valid)
                $display("FAIL wht_addr_valid cfg=%0d t=%0d: got %b expected %b", cfg, t, wht_addr_valid, prev_valid);
            else passes++;
            exp_done = (exp_q.size() == 0) ? (t == 2) : (last_t > 0 && t == last_t + 2);
            checks++;
            if (done !== exp_done || busy !== 1'b1)
                $display("FAIL done_busy cfg=%0d t=%0d: got done=%b busy=%b expected done=%b busy=1",
                         cfg, t, done, busy, exp_done);
            else passes++;
            if (done === 1'b1) begin
                finished = 1;
                done_t = t;
            end
            prev_valid = exp_valid;
            stall = ((t < 64) ? stall_mask[t] : 1'b0) | (int'($urandom_range(0, 99)) < stall_pct);
            prev_stall = stall;
            start = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
            if (finished && noisy_start) start = 1'b1;
            step();
            t++;
        end
        if (!finished) begin
            checks++;
            $display("FAIL timeout cfg=%0d: no done within budget", cfg);
        end
        start = 1'b0; stall = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || seq_valid !== 1'b0 || wht_addr_valid !== 1'b0 || bi != exp_q.size())
            $display("FAIL post_done cfg=%0d: got busy=%b done=%b valid=%b wht=%b beats=%0d expected 0 0 0 0 beats=%0d",
                     cfg, busy, done, seq_valid, wht_addr_valid, bi, exp_q.size());
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; cfg_num_iter = '0;
        step(); step();
        checks++;
        if ({busy, done, gray_code, sequence_selector, seq_data_addr, seq_valid, wht_addr_valid} !== 10'b00_00_1_000_00)
            $display("FAIL reset_values: got %b expected 0000100000",
                     {busy, done, gray_code, sequence_selector, seq_data_addr, seq_valid, wht_addr_valid});
        else passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_iter();
        int dt;
        run_job(1, 0, 64'd0, 0, dt);
        checks++;
        if (dt != 12) $display("FAIL single_done_time: got %0d expected 12", dt);
        else passes++;
    endtask

    task automatic test_gray_wrap();
        int dt;
        run_job(5, 0, 64'd0, 0, dt);
        checks++;
        if (dt != 52) $display("FAIL gray_wrap_done_time: got %0d expected 52", dt);
        else passes++;
    endtask

    task automatic test_stall();
        int dt;
        run_job(1, 0, 64'h1C, 0, dt);
        checks++;
        if (dt != 15) $display("FAIL stall_done_time: got %0d expected 15", dt);
        else passes++;
    endtask

    task automatic test_zero_iter();
        int dt;
        run_job(0, 30, 64'd0, 0, dt);
        checks++;
        if (dt != 2) $display("FAIL zero_done_time: got %0d expected 2", dt);
        else passes++;
    endtask

    task automatic test_rst_mid_job();
        int seen, t, dt;
        bit bad_done;
        seen = 0; t = 0;
        cfg_num_iter = ITER_W'(3); start = 1'b1; stall = 1'b0;
        step();
        start = 1'b0;
        while (t < 200) begin
            if (seq_valid === 1'b1) seen++;
            if (seen == 12) break;
            step();
            t++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done, gray_code, sequence_selector, seq_data_addr, seq_valid, wht_addr_valid} !== 10'b00_00_1_000_00 || seen != 12)
            $display("FAIL rst_mid_job: got %b beats=%0d expected 0000100000 beats=12",
                     {busy, done, gray_code, sequence_selector, seq_data_addr, seq_valid, wht_addr_valid}, seen);
        else passes++;
        bad_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) bad_done = 1;
        end
        checks++;
        if (bad_done) $display("FAIL rst_no_done: got activity after reset expected none");
        else passes++;
        run_job(1, 0, 64'd0, 0, dt);
        checks++;
        if (dt != 12) $display("FAIL rst_rerun_done_time: got %0d expected 12", dt);
        else passes++;
    endtask

    task automatic test_start_ignored();
        int dt;
        run_job(2, 0, 64'd0, 1, dt);
        checks++;
        if (dt != 22) $display("FAIL noisy_start_done_time: got %0d expected 22", dt);
        else passes++;
        run_job(1, 0, 64'd0, 0, dt);
        checks++;
        if (dt != 12) $display("FAIL back_to_back_done_time: got %0d expected 12", dt);
        else passes++;
    endtask

    task automatic test_random();
        int dt;
        for (int j = 0; j < 6; j++)
            run_job(int'($urandom_range(1, 6)), 30, 64'd0, 1, dt);
    endtask

    initial begin
        test_reset();
        test_single_iter();
        test_gray_wrap();
        test_stall();
        test_zero_iter();
        test_rst_mid_job();
        test_start_ignored();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
